ps2_byte_receiver: RTL and testbench

//  PS/2 device-to-host byte deserializer. Samples raw ps2ck/ps2dt in the CLOCK domain and recovers 11-bit frames.
//  It delivers each valid byte with a one-cycle strobe to the mouse packet decoder (ps2Mouse), which consumes

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_line_filter.sv | 54 +++++
 rtl/ps2_byte_receiver.sv | 164 ++++++++++++++++
 tb/tb_ps2_byte_receiver.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: frame geometry, FSM state encoding and parity helper.
package ps2_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StData   = 2'd1,
    StParity = 2'd2,
    StStop   = 2'd3
  } ps2_state_e;

  // PS/2 uses odd parity across the data byte and the parity bit
  function automatic logic ps2_parity_ok(input logic [PS2_DATA_BITS-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a glitch filter; the output only moves after FILTER_LEN
// consecutive synchronized samples agree on the new level. Idles high out of reset.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic CLOCK,
  input  logic reset,
  input  logic raw,
  output logic filtered
);

  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FILTER_LEN - 1);

  logic [1:0]      sync_q;
  logic            filt_q, filt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sampled;

  assign sampled  = sync_q[1];
  assign filtered = filt_q;

  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  // cnt_q holds how many consecutive samples already disagreed with the output
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sampled != filt_q) begin
      if (cnt_q == CntLast) begin
        filt_d = sampled;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_byte_receiver.sv
// PS/2 device-to-host byte deserializer: conditions raw lines, frames 11-bit words on filtered
// clock falls, checks start/parity/stop and aborts stalled frames after TIMEOUT_CYCLES.
module ps2_byte_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                     CLOCK,
  input  logic                     reset,
  input  logic                     ps2ck,
  input  logic                     ps2dt,
  output logic [PS2_DATA_BITS-1:0] received_data,
  output logic                     received_data_en,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     timeout_err
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES);

  logic ck_filt, dt_filt;
  logic ck_prev_q;
  logic fall;
  logic timeout;

  ps2_state_e              state_q, state_d;
  logic [PS2_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic                    par_q, par_d;
  logic [TmoW-1:0]         tmo_q, tmo_d;
  logic [PS2_DATA_BITS-1:0] data_q, data_d;
  logic                    en_q, en_d;
  logic                    perr_q, perr_d;
  logic                    ferr_q, ferr_d;
  logic                    terr_q, terr_d;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_ck_filter (
    .CLOCK   (CLOCK),
    .reset   (reset),
    .raw     (ps2ck),
    .filtered(ck_filt)
  );

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_dt_filter (
    .CLOCK   (CLOCK),
    .reset   (reset),
    .raw     (ps2dt),
    .filtered(dt_filt)
  );

  assign fall    = ck_prev_q & ~ck_filt;
  // A fall in the same cycle as the limit wins, so the frame keeps going
  assign timeout = (state_q != StIdle) && !fall && (tmo_q == TmoMax);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    data_d    = data_q;
    en_d      = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    terr_d    = 1'b0;

    if (state_q == StIdle || fall) begin
      tmo_d = '0;
    end else if (tmo_q != TmoMax) begin
      tmo_d = tmo_q + TmoW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (fall) begin
          if (!dt_filt) begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      StData: begin
        if (fall) begin
          shreg_d   = {dt_filt, shreg_q[PS2_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
      end
      StParity: begin
        if (fall) begin
          par_d   = dt_filt;
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          state_d = StIdle;
          if (!dt_filt) begin
            ferr_d = 1'b1;
          end else if (ps2_parity_ok(shreg_q, par_q)) begin
            data_d = shreg_q;
            en_d   = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (timeout) begin
      state_d   = StIdle;
      shreg_d   = '0;
      bit_cnt_d = 3'd0;
      tmo_d     = '0;
      terr_d    = 1'b1;
    end
  end

  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      ck_prev_q <= 1'b1;
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= 3'd0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      data_q    <= '0;
      en_q      <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      ck_prev_q <= ck_filt;
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      data_q    <= data_d;
      en_q      <= en_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      terr_q    <= terr_d;
    end
  end

  assign received_data    = data_q;
  assign received_data_en = en_q;
  assign parity_err       = perr_q;
  assign frame_err        = ferr_q;
  assign timeout_err      = terr_q;

endmodule

// File: tb/tb_ps2_byte_receiver.sv
// Directed bench for ps2_byte_receiver: drives PS/2 frames from a line model and checks
// bytes, one-cycle pulses, stop-to-strobe latency, timeout, glitch rejection and mid-frame reset.
module tb_ps2_byte_receiver;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 50000;
  // PS/2 half-period in CLOCK cycles, shortened from 12 kHz to keep the run short
  localparam int HALF           = 40;
  localparam int LATENCY        = 2 + FILTER_LEN + 1;

  logic       CLOCK = 1'b0;
  logic       reset = 1'b0;
  logic       ps2ck = 1'b1;
  logic       ps2dt = 1'b1;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       parity_err;
  logic       frame_err;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;

  int unsigned cyc = 0;
  int unsigned fall_cyc = 0;
  int unsigned en_cyc = 0, perr_cyc = 0, terr_cyc = 0;
  int n_en = 0, n_perr = 0, n_ferr = 0, n_terr = 0, n_dbl = 0, n_rst_pulse = 0;
  logic en_p = 1'b0, perr_p = 1'b0, ferr_p = 1'b0, terr_p = 1'b0;

  ps2_byte_receiver #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .CLOCK           (CLOCK),
    .reset           (reset),
    .ps2ck           (ps2ck),
    .ps2dt           (ps2dt),
    .received_data   (received_data),
    .received_data_en(received_data_en),
    .parity_err      (parity_err),
    .frame_err       (frame_err),
    .timeout_err     (timeout_err)
  );

  always #10 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc <= cyc + 1;

  // Pulse monitor, sampled away from the active edge
  always @(negedge CLOCK) begin
    if (received_data_en) begin
      n_en   <= n_en + 1;
      en_cyc <= cyc;
    end
    if (parity_err) begin
      n_perr   <= n_perr + 1;
      perr_cyc <= cyc;
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (timeout_err) begin
      n_terr   <= n_terr + 1;
      terr_cyc <= cyc;
    end
    if ((received_data_en && en_p) || (parity_err && perr_p) ||
        (frame_err && ferr_p) || (timeout_err && terr_p)) n_dbl <= n_dbl + 1;
    if (!reset && (received_data_en || parity_err || frame_err || timeout_err))
      n_rst_pulse <= n_rst_pulse + 1;
    en_p   <= received_data_en;
    perr_p <= parity_err;
    ferr_p <= frame_err;
    terr_p <= timeout_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  // One bit: data changes mid-high, then ck falls; optional dt glitch early in the low phase
  task automatic ps2_bit(input logic b, input bit glitch);
    wait_cycles(HALF / 2);
    ps2dt = b;
    wait_cycles(HALF / 2);
    ps2ck    = 1'b0;
    fall_cyc = cyc;
    if (glitch) begin
      wait_cycles(3);
      ps2dt = ~b;
      wait_cycles(5);
      ps2dt = b;
      wait_cycles(HALF - 8);
    end else begin
      wait_cycles(HALF);
    end
    ps2ck = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int nbits,
                            input bit glitch);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i], glitch);
    wait_cycles(HALF);
    ps2dt = 1'b1;
  endtask

  initial begin
    // Reset state
    wait_cycles(5);
    chk("rst_data", {24'h0, received_data}, 32'h0);
    chk("rst_en", {31'h0, received_data_en}, 32'h0);
    chk("rst_perr", {31'h0, parity_err}, 32'h0);
    chk("rst_ferr", {31'h0, frame_err}, 32'h0);
    chk("rst_terr", {31'h0, timeout_err}, 32'h0);
    reset = 1'b1;
    wait_cycles(20);

    // 1: good byte 0x08
    send_frame(8'h08, 1'b0, 1'b1, 11, 1'b0);
    wait_cycles(30);
    chk("t1_en_count", n_en, 1);
    chk("t1_data", {24'h0, received_data}, 32'h08);
    chk("t1_latency", en_cyc - fall_cyc, LATENCY);
    chk("t1_no_err", n_perr + n_ferr + n_terr, 0);

    // 2: 0xFA with wrong parity
    send_frame(8'hFA, 1'b0, 1'b1, 11, 1'b0);
    wait_cycles(30);
    chk("t2_perr_count", n_perr, 1);
    chk("t2_perr_latency", perr_cyc - fall_cyc, LATENCY);
    chk("t2_en_count", n_en, 1);
    chk("t2_data_held", {24'h0, received_data}, 32'h08);

    // 3: 0x55 with bad stop bit
    send_frame(8'h55, 1'b1, 1'b0, 11, 1'b0);
    wait_cycles(30);
    chk("t3_ferr_count", n_ferr, 1);
    chk("t3_en_count", n_en, 1);
    chk("t3_perr_count", n_perr, 1);

    // 4: stall after start + 4 data bits, then a fresh 0x00 frame
    send_frame(8'h0F, 1'b1, 1'b1, 5, 1'b0);
    wait_cycles(TIMEOUT_CYCLES - 150);
    chk("t4_no_early_timeout", n_terr, 0);
    wait_cycles(250);
    chk("t4_terr_count", n_terr, 1);
    chk("t4_terr_latency_ok",
        {31'h0, (terr_cyc - fall_cyc >= TIMEOUT_CYCLES + 10) &&
                (terr_cyc - fall_cyc <= TIMEOUT_CYCLES + 13)}, 32'h1);
    chk("t4_data_held", {24'h0, received_data}, 32'h08);
    send_frame(8'h00, 1'b1, 1'b1, 11, 1'b0);
    wait_cycles(30);
    chk("t4_en_count", n_en, 2);
    chk("t4_data", {24'h0, received_data}, 32'h00);
    chk("t4_terr_once", n_terr, 1);

    // 5: 3-cycle ck glitch at idle, then 0xC3 with dt glitches mid-bit
    ps2ck = 1'b0;
    wait_cycles(3);
    ps2ck = 1'b1;
    wait_cycles(40);
    chk("t5_ck_glitch_ignored", n_ferr + n_en, 1 + 2);
    send_frame(8'hC3, 1'b1, 1'b1, 11, 1'b1);
    wait_cycles(30);
    chk("t5_en_count", n_en, 3);
    chk("t5_data", {24'h0, received_data}, 32'hC3);
    chk("t5_no_new_err", n_perr + n_ferr, 2);

    // 6: reset after start + 6 data bits, then 0x3C
    send_frame(8'hA5, 1'b1, 1'b1, 7, 1'b0);
    @(negedge CLOCK);
    reset = 1'b0;
    #1;
    chk("t6_rst_data", {24'h0, received_data}, 32'h0);
    chk("t6_rst_pulses", {28'h0, received_data_en, parity_err, frame_err, timeout_err}, 32'h0);
    wait_cycles(10);
    reset = 1'b1;
    wait_cycles(20);
    send_frame(8'h3C, 1'b1, 1'b1, 11, 1'b0);
    wait_cycles(30);
    chk("t6_en_count", n_en, 4);
    chk("t6_data", {24'h0, received_data}, 32'h3C);
    chk("t6_err_totals", n_perr + n_ferr + n_terr, 3);
    chk("no_pulse_in_reset", n_rst_pulse, 0);
    chk("single_cycle_pulses", n_dbl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
